mul_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath, extending ALU control decoding with the R-type funct codes the single-cycle ALU cannot execute: mult, multu, div, divu, mfhi, mflo, mthi, mtlo. It sits beside the ALU and is issued by the same alu_op/funct pair. Iterative shift-add multiply and restoring divide run one bit per cycle. A stall output interlocks the pipeline while an operation is in flight.

---
 rtl/mul_div_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Purpose : iterative MIPS multiply/divide unit with HI/LO registers (mult, multu, div, divu, mfhi, mflo, mthi, mtlo).
// Latency : mult/div take WIDTH busy cycles plus one DONE cycle; div by zero and mthi/mtlo finish on the issue edge.
// Backpres: stall is raised for any request presented while not IDLE; the request is dropped and must be held/retried.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alu_op, funct       ALU class (responds to 2'b10 only) and R-type function field
//   start               issue strobe qualifying the decode
//   rs_val, rt_val      operand A (dividend/multiplicand/mthi-mtlo source), operand B (divisor/multiplier)
//   busy, done          in MUL/DIV state; one-cycle completion pulse
//   stall               combinational interlock
//   div_by_zero         one-cycle pulse with done for a zero divisor
//   hi, lo, result      HI/LO registers and the mfhi/mflo read value
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic             start,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   // work_q holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
   logic [2*WIDTH-1:0]     work_q, work_d;
   logic [WIDTH-1:0]       opb_q, opb_d;      // multiplicand or divisor magnitude
   logic                   neg_res_q, neg_res_d;
   logic                   neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]       hi_q, hi_d;
   logic [WIDTH-1:0]       lo_q, lo_d;
   logic                   dbz_q, dbz_d;

   // ---------------- decode ----------------
   logic is_r, is_mul, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo, req;
   logic signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign is_r    = (alu_op == 2'b10) && start;
   assign is_mul  = is_r && ((funct == F_MULT) || (funct == F_MULTU));
   assign is_div  = is_r && ((funct == F_DIV)  || (funct == F_DIVU));
   assign is_mfhi = is_r && (funct == F_MFHI);
   assign is_mflo = is_r && (funct == F_MFLO);
   assign is_mthi = is_r && (funct == F_MTHI);
   assign is_mtlo = is_r && (funct == F_MTLO);
   assign req     = is_mul || is_div || is_mfhi || is_mflo || is_mthi || is_mtlo;

   // mult and div have funct[0]==0; the unsigned variants have it set
   assign signed_op = ~funct[0];
   assign a_neg     = signed_op & rs_val[WIDTH-1];
   assign b_neg     = signed_op & rt_val[WIDTH-1];
   assign a_mag     = a_neg ? (~rs_val + 1'b1) : rs_val;
   assign b_mag     = b_neg ? (~rt_val + 1'b1) : rt_val;

   // ---------------- iteration datapath ----------------
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next, mul_prod;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH-1:0]     div_sub;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_next;
   logic [WIDTH-1:0]     div_quo, div_rem;

   // Shift-add: conditionally add multiplicand to the upper half, then shift the pair right
   assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, work_q[WIDTH-1:1]};
   assign mul_prod = neg_res_q ? (~mul_next + 1'b1) : mul_next;

   // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
   // When it fits the difference is below the divisor, so WIDTH-bit arithmetic suffices.
   assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, opb_q});
   assign div_sub   = div_shift[WIDTH-1:0] - opb_q;
   assign div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};
   // Most-negative / -1 gives magnitude 2^(W-1); negating it wraps back to most-negative, no trap
   assign div_quo   = neg_res_q ? (~div_next[WIDTH-1:0] + 1'b1) : div_next[WIDTH-1:0];
   assign div_rem   = neg_rem_q ? (~div_next[2*WIDTH-1:WIDTH] + 1'b1) : div_next[2*WIDTH-1:WIDTH];

   // ---------------- next state ----------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      opb_d     = opb_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (is_mul) begin
               state_d   = S_MUL;
               cnt_d     = '0;
               work_d    = {{WIDTH{1'b0}}, b_mag};
               opb_d     = a_mag;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
            end else if (is_div) begin
               if (rt_val == '0) begin
                  state_d = S_DONE;
                  hi_d    = rs_val;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
               end else begin
                  state_d   = S_DIV;
                  cnt_d     = '0;
                  work_d    = {{WIDTH{1'b0}}, a_mag};
                  opb_d     = b_mag;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
               end
            end else if (is_mthi) begin
               hi_d = rs_val;
            end else if (is_mtlo) begin
               lo_d = rs_val;
            end
         end
         S_MUL: begin
            work_d = mul_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_IT) begin
               state_d      = S_DONE;
               cnt_d        = '0;
               {hi_d, lo_d} = mul_prod;
            end
         end
         S_DIV: begin
            work_d = div_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_IT) begin
               state_d = S_DONE;
               cnt_d   = '0;
               hi_d    = div_rem;
               lo_d    = div_quo;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         opb_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         opb_q     <= opb_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
      end
   end

   // ---------------- outputs ----------------
   assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;
   assign stall       = req && (state_q != S_IDLE);
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign result      = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

   localparam int W = 32;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   alu_op;
   logic [5:0]   funct;
   logic         start;
   logic [W-1:0] rs_val, rt_val;
   logic         busy, done, stall, div_by_zero;
   logic [W-1:0] hi, lo, result;

   int checks   = 0;
   int failures = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_op      (alu_op),
      .funct       (funct),
      .start       (start),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .busy        (busy),
      .done        (done),
      .stall       (stall),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo),
      .result      (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [5:0]   funct;
      logic [W-1:0] rs;
      logic [W-1:0] rt;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
      logic         exp_dbz;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Returns at the falling edge where done is seen (or after the cycle budget)
   task automatic wait_done(output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (busy) bcnt++;
         if (done || cyc > 200) break;
      end
      chk("done_within_budget", {31'b0, done}, 32'd1);
   endtask

   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      alu_op = 2'b10;
      funct  = f;
      rs_val = a;
      rt_val = b;
      start  = 1'b1;
      #1 chk("issue_no_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int cyc, bcnt;
      issue(v.funct, v.rs, v.rt);
      wait_done(cyc, bcnt);
      chk({v.name, "_latency"}, 32'(cyc), v.exp_dbz ? 32'd1 : 32'(W + 1));
      chk({v.name, "_busy_cycles"}, 32'(bcnt), v.exp_dbz ? 32'd0 : 32'(W));
      chk({v.name, "_hi"}, hi, v.exp_hi);
      chk({v.name, "_lo"}, lo, v.exp_lo);
      chk({v.name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, v.exp_dbz});
      @(negedge clk);
      chk({v.name, "_done_pulse"}, {31'b0, done}, 32'd0);
      alu_op = 2'b10;
      funct  = F_MFLO;
      start  = 1'b1;
      #1 chk({v.name, "_mflo"}, result, v.exp_lo);
      chk({v.name, "_mflo_stall"}, {31'b0, stall}, 32'd0);
      funct = F_MFHI;
      #1 chk({v.name, "_mfhi"}, result, v.exp_hi);
      start = 1'b0;
   endtask

   initial begin
      int cyc, bcnt, dcount;
      vec_t v;

      vecs[0]  = '{"multu_ffff_x2",   F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      vecs[1]  = '{"mult_m3_x7",      F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{"div_m7_2",        F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{"divu_100_7",      F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[4]  = '{"div_minneg_m1",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5]  = '{"divu_by_zero",    F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
      vecs[6]  = '{"mult_minneg_sq",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[7]  = '{"mult_m1_m1",      F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      vecs[8]  = '{"multu_max_sq",    F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[9]  = '{"div_7_m2",        F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[10] = '{"div_by_zero_s",   F_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};

      rst    = 1'b1;
      alu_op = 2'b00;
      funct  = 6'b0;
      start  = 1'b0;
      rs_val = '0;
      rt_val = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // mthi/mtlo in IDLE give known HI/LO for the interlock sequence
      issue(F_MTHI, 32'h11112222, 32'd0);
      chk("mthi_write", hi, 32'h11112222);
      chk("mthi_no_busy", {31'b0, busy}, 32'd0);
      issue(F_MTLO, 32'h33334444, 32'd0);
      chk("mtlo_write", lo, 32'h33334444);
      chk("mtlo_no_done", {31'b0, done}, 32'd0);

      // Requests during a multiply are stalled and dropped
      issue(F_MULT, 32'd2, 32'd3);
      repeat (3) @(negedge clk);
      alu_op = 2'b10;
      funct  = F_MFHI;
      start  = 1'b1;
      #1 chk("busy_mfhi_stall", {31'b0, stall}, 32'd1);
      chk("busy_mfhi_old", result, 32'h11112222);
      funct  = F_MTHI;
      rs_val = 32'hDEADBEEF;
      #1 chk("busy_mthi_stall", {31'b0, stall}, 32'd1);
      @(posedge clk);
      #1 chk("busy_mthi_dropped", hi, 32'h11112222);
      chk("busy_still", {31'b0, busy}, 32'd1);
      funct  = F_MULT;
      rs_val = 32'd9;
      rt_val = 32'd9;
      #1 chk("busy_mult_stall", {31'b0, stall}, 32'd1);
      alu_op = 2'b00;
      funct  = F_MULT;
      #1 chk("non_rtype_no_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1 chk("non_rtype_hi", hi, 32'h11112222);
      start  = 1'b0;
      alu_op = 2'b10;
      wait_done(cyc, bcnt);
      chk("interlock_mult_hi", hi, 32'd0);
      chk("interlock_mult_lo", lo, 32'd6);
      @(negedge clk);
      issue(F_MTLO, 32'hA5A5A5A5, 32'd0);
      chk("mtlo_after_done", lo, 32'hA5A5A5A5);
      chk("mtlo_after_done_busy", {31'b0, busy}, 32'd0);

      // Back-to-back: request held through DONE is accepted from IDLE
      issue(F_MULTU, 32'd3, 32'd5);
      wait_done(cyc, bcnt);
      chk("b2b_first_lo", lo, 32'd15);
      alu_op = 2'b10;
      funct  = F_MULTU;
      rs_val = 32'd2;
      rt_val = 32'd2;
      start  = 1'b1;
      #1 chk("b2b_done_stall", {31'b0, stall}, 32'd1);
      @(negedge clk);
      #1 chk("b2b_idle_no_stall", {31'b0, stall}, 32'd0);
      chk("b2b_idle_not_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(cyc, bcnt);
      chk("b2b_latency", 32'(cyc), 32'(W + 1));
      chk("b2b_second_lo", lo, 32'd4);
      @(negedge clk);

      // Reset in the middle of a divide aborts it
      issue(F_DIVU, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("midrst_no_done", 32'(dcount), 32'd0);
      v = '{"post_rst_multu", F_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0};
      run_vec(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
